mem_stage_lsu: RTL and testbench
================================

Name: mem_stage_lsu

Overview:
- Parametrised successor to the pipeline memory stage: load/store unit plus MEM/WB pipeline register for the RISC-V core.
- Drives an external data memory over a request/grant/response handshake, so memory latency is variable and the pipeline stalls while an access is outstanding.
- Adds byte-lane strobes, load extraction with sign/zero extension, misalignment detection, a response timeout and a writeback flush.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- REG_W, 5, register index width.
- RSP_TIMEOUT, 16, maximum cycles spent in WAIT_RSP; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- ValidM  in  1  instruction in M stage is valid.
- RegWriteM, MemWriteM, MemReadM  in  1 each  control signals from EX/MEM.
- ResultSrcM  in  2  writeback mux select.
- Funct3M  in  3  access size and signedness.
- ALUResultM  in  XLEN  effective address / ALU result.
- WriteDataM  in  XLEN  store data, LSB-aligned.
- PCPlus4M, AuLu_ResultM  in  XLEN  passthrough values.
- RdM  in  REG_W  destination register.
- FlushW  in  1  force a bubble into the W register.
- dmem_req  out  1  request valid.
- dmem_we  out  1  1 = store.
- dmem_addr  out  XLEN  address with the low log2(XLEN/8) bits cleared.
- dmem_wdata  out  XLEN  store data replicated and shifted into its lanes.
- dmem_be  out  XLEN/8  byte enables.
- dmem_gnt  in  1  memory accepts the request this cycle.
- dmem_rvalid  in  1  load data valid.
- dmem_rdata  in  XLEN  load data, whole aligned word.
- StallM  out  1  hold IF/ID/EX/M stages.
- MisalignM  out  1  one-cycle misaligned-access flag.
- BusErrM  out  1  one-cycle response-timeout flag.
- RegWriteW  out  1
- ResultSrcW  out  2
- ReadDataW, ALUResultW, PCPlus4W, AuLu_ResultW  out  XLEN
- RdW  out  REG_W

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - State goes to IDLE; timeout counter cleared.
  - All W outputs become 0.
  - dmem_req, StallM, MisalignM and BusErrM are 0 in the cycle after reset.
  - Reset mid-access abandons the access. A late dmem_rvalid arriving in IDLE is ignored.
- Access decode: a memory op is ValidM & (MemReadM | MemWriteM).
  - Size comes from Funct3M[1:0]: 00 byte, 01 half, 10 word, 11 double.
  - Double is legal only when XLEN=64; at XLEN=32 it is treated as misaligned.
  - Funct3M[2]=1 selects zero-extension for loads.
- Alignment: misaligned when the address is not a multiple of the access size.
  - No dmem_req is issued; MisalignM=1 combinationally in that cycle; StallM=0.
  - W captures a bubble (RegWriteW=0, RdW=0).
- FSM:
  - IDLE: a legal memory op drives dmem_req=1 combinationally.
    - gnt=1 and store: the access completes this cycle.
    - gnt=1 and load: go to WAIT_RSP.
    - gnt=0: go to WAIT_GNT.
  - WAIT_GNT: dmem_req and all request fields are held stable. On gnt, a store completes; a load goes to WAIT_RSP.
  - WAIT_RSP: dmem_req=0; the counter increments each cycle.
    - dmem_rvalid=1: the load completes and the next state is IDLE.
    - Counter reaches RSP_TIMEOUT-1 without rvalid: BusErrM=1 for one cycle, W takes a bubble, next state is IDLE.
    - rvalid and timeout in the same cycle: rvalid wins.
- StallM: 1 in every cycle a legal memory op is present and not completing this cycle; 0 on the completion cycle.
  - Non-memory instructions never stall: 1-cycle latency, same as the plain register stage.
- W register:
  - On a completion cycle or a non-memory cycle: captures M values. ReadDataW is the extracted load data, or 0 for non-loads.
  - On a stall cycle: captures a bubble, so there is exactly one writeback per instruction.
  - FlushW=1 overrides everything with a bubble; it does not abort the in-flight access.
- Load extraction:
  - lane = addr[log2(XLEN/8)-1:0].
  - The selected byte/half/word is shifted down to the LSB.
  - Sign-extended to XLEN when Funct3M[2]=0, zero-extended otherwise.
- Store: dmem_be has ones in exactly the accessed lanes; dmem_wdata places WriteDataM into those lanes.

Test Plan:
- Word load (LW, XLEN=32), addr 0x104; gnt same cycle; rvalid after 3 cycles with rdata 0xDEADBEEF.
  -> StallM high for 3 cycles; one W cycle with RegWriteW=1, ReadDataW=0xDEADBEEF; bubbles during the stall.
- LB at 0x103 with rdata 0x80FF1234 -> ReadDataW 0xFFFFFF80.
- LBU at the same address -> ReadDataW 0x00000080.
- LH at 0x102 -> ReadDataW 0xFFFF80FF.
- SB at 0x101 with WriteDataM 0x000000AB; gnt delayed 2 cycles.
  -> dmem_be=0010, dmem_wdata[15:8]=0xAB, dmem_addr=0x100 held stable for 3 cycles; StallM high for 2 cycles.
- LW at 0x102 -> MisalignM=1 for one cycle, no dmem_req, StallM=0, RegWriteW=0.
- RSP_TIMEOUT=4, load granted, no rvalid.
  -> BusErrM=1 in the 4th WAIT_RSP cycle; StallM drops the same cycle; FSM returns to IDLE; a late rvalid is ignored.
- rst asserted in WAIT_RSP with FlushW=1 on the following op.
  -> next cycle all W outputs are 0 and dmem_req=0; the flushed op produces RegWriteW=0.

Source files
------------

// File: rtl/mem_stage_lsu_if.sv
// Data-memory bus between the load/store unit and an external data memory.
// The LSU drives a request (address, write data, byte enables, direction)
// and waits for the memory to grant it; load data comes back later with rvalid.
//
// Signals:
//   dmem_req     LSU -> mem  request valid
//   dmem_we      LSU -> mem  1 = store, 0 = load
//   dmem_addr    LSU -> mem  word-aligned address
//   dmem_wdata   LSU -> mem  store data already placed in its byte lanes
//   dmem_be      LSU -> mem  byte-lane enables
//   dmem_gnt     mem -> LSU  request accepted this cycle
//   dmem_rvalid  mem -> LSU  load data valid
//   dmem_rdata   mem -> LSU  whole aligned load word
interface mem_stage_lsu_if #(
    parameter int XLEN = 32
);
    logic              dmem_req;
    logic              dmem_we;
    logic [XLEN-1:0]   dmem_addr;
    logic [XLEN-1:0]   dmem_wdata;
    logic [XLEN/8-1:0] dmem_be;
    logic              dmem_gnt;
    logic              dmem_rvalid;
    logic [XLEN-1:0]   dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// Pipeline memory stage: load/store unit plus MEM/WB register.
// Issues data-memory accesses over a req/gnt/rvalid handshake, stalls the
// front of the pipeline while an access is outstanding, extracts and extends
// load data, flags misaligned accesses and response timeouts, and registers
// the writeback values.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   ValidM .. RdM       M-stage instruction fields (address in ALUResultM)
//   FlushW              force a bubble into the W register
//   bus                 data-memory bus (master side)
//   StallM              hold IF/ID/EX/M while an access is pending
//   MisalignM           misaligned access seen this cycle (no request issued)
//   BusErrM             load response timed out this cycle
//   RegWriteW .. RdW    W-stage register outputs
module mem_stage_lsu #(
    parameter int XLEN        = 32,
    parameter int REG_W       = 5,
    parameter int RSP_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ValidM,
    input  logic             RegWriteM,
    input  logic             MemWriteM,
    input  logic             MemReadM,
    input  logic [1:0]       ResultSrcM,
    input  logic [2:0]       Funct3M,
    input  logic [XLEN-1:0]  ALUResultM,
    input  logic [XLEN-1:0]  WriteDataM,
    input  logic [XLEN-1:0]  PCPlus4M,
    input  logic [XLEN-1:0]  AuLu_ResultM,
    input  logic [REG_W-1:0] RdM,
    input  logic             FlushW,
    mem_stage_lsu_if.master  bus,
    output logic             StallM,
    output logic             MisalignM,
    output logic             BusErrM,
    output logic             RegWriteW,
    output logic [1:0]       ResultSrcW,
    output logic [XLEN-1:0]  ReadDataW,
    output logic [XLEN-1:0]  ALUResultW,
    output logic [XLEN-1:0]  PCPlus4W,
    output logic [XLEN-1:0]  AuLu_ResultW,
    output logic [REG_W-1:0] RdW
);

    localparam int BE_W   = XLEN / 8;
    localparam int LANE_W = $clog2(BE_W);
    localparam int CNT_W  = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((RSP_TIMEOUT > 0) ? RSP_TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_GNT,
        WAIT_RSP
    } lsuState_t;

    lsuState_t         state;
    lsuState_t         stateNext;
    logic [CNT_W-1:0]  rspCnt;
    logic              memOp;
    logic              misaligned;
    logic              timeoutHit;
    logic              req;
    logic              loadDone;
    logic              wBubble;
    logic [1:0]        accSize;
    logic [2:0]        alignMask;
    logic [LANE_W-1:0] lane;

    // Byte enables for an access of the given size starting at lane 0.
    function automatic logic [BE_W-1:0] laneMask(input logic [1:0] size);
        logic [BE_W-1:0] m;
        case (size)
            2'b00:   m = BE_W'(1);
            2'b01:   m = BE_W'(3);
            2'b10:   m = BE_W'(15);
            default: m = '1;
        endcase
        return m;
    endfunction

    // Replicating the store datum across the word puts a copy in every lane
    // the access can start at, so byte enables alone select the right one.
    function automatic logic [XLEN-1:0] storeData(input logic [1:0] size,
                                                  input logic [XLEN-1:0] data);
        logic [XLEN-1:0] d;
        case (size)
            2'b00:   d = {BE_W{data[7:0]}};
            2'b01:   d = {(XLEN/16){data[15:0]}};
            2'b10:   d = {(XLEN/32){data[31:0]}};
            default: d = data;
        endcase
        return d;
    endfunction

    // Shift the addressed lane down to bit 0, then sign- or zero-extend.
    function automatic logic [XLEN-1:0] extractLoad(input logic [XLEN-1:0]   word,
                                                    input logic [LANE_W-1:0] ln,
                                                    input logic [2:0]        f3);
        logic [XLEN-1:0] sh;
        logic [XLEN-1:0] mask;
        logic            sgn;
        sh = word >> {ln, 3'b000};
        case (f3[1:0])
            2'b00:   begin mask = XLEN'(8'hFF);          sgn = sh[7];      end
            2'b01:   begin mask = XLEN'(16'hFFFF);       sgn = sh[15];     end
            2'b10:   begin mask = XLEN'(32'hFFFF_FFFF);  sgn = sh[31];     end
            default: begin mask = '1;                    sgn = sh[XLEN-1]; end
        endcase
        return (sh & mask) | ((sgn && !f3[2]) ? ~mask : '0);
    endfunction

    assign accSize = Funct3M[1:0];
    assign lane    = ALUResultM[LANE_W-1:0];
    assign memOp   = ValidM && (MemReadM || MemWriteM);

    always_comb begin
        alignMask = 3'b000;
        case (accSize)
            2'b00:   alignMask = 3'b000;
            2'b01:   alignMask = 3'b001;
            2'b10:   alignMask = 3'b011;
            default: alignMask = 3'b111;
        endcase
    end

    // Doubleword accesses only exist on a 64-bit datapath.
    assign misaligned = ((XLEN == 32) && (accSize == 2'b11)) ||
                        (|(ALUResultM[2:0] & alignMask));

    assign timeoutHit = (RSP_TIMEOUT != 0) && (rspCnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            rspCnt <= '0;
        end else begin
            state  <= stateNext;
            rspCnt <= (state == WAIT_RSP && stateNext == WAIT_RSP) ? rspCnt + CNT_W'(1) : '0;
        end
    end

    // Request fields come straight from the M inputs; StallM freezes those
    // inputs, which keeps the request stable while waiting for the grant.
    always_comb begin
        stateNext = state;
        req       = 1'b0;
        StallM    = 1'b0;
        MisalignM = 1'b0;
        BusErrM   = 1'b0;
        loadDone  = 1'b0;
        case (state)
            IDLE: begin
                if (memOp) begin
                    if (misaligned) begin
                        MisalignM = 1'b1;
                    end else begin
                        req = 1'b1;
                        if (!bus.dmem_gnt) begin
                            stateNext = WAIT_GNT;
                            StallM    = 1'b1;
                        end else if (!MemWriteM) begin
                            stateNext = WAIT_RSP;
                            StallM    = 1'b1;
                        end
                    end
                end
            end
            WAIT_GNT: begin
                req    = 1'b1;
                StallM = 1'b1;
                if (bus.dmem_gnt) begin
                    if (MemWriteM) begin
                        stateNext = IDLE;
                        StallM    = 1'b0;
                    end else begin
                        stateNext = WAIT_RSP;
                    end
                end
            end
            WAIT_RSP: begin
                // A response in the timeout cycle still counts as success.
                if (bus.dmem_rvalid) begin
                    loadDone  = 1'b1;
                    stateNext = IDLE;
                end else if (timeoutHit) begin
                    BusErrM   = 1'b1;
                    stateNext = IDLE;
                end else begin
                    StallM = 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    assign bus.dmem_req   = req;
    assign bus.dmem_we    = MemWriteM;
    assign bus.dmem_addr  = {ALUResultM[XLEN-1:LANE_W], LANE_W'(0)};
    assign bus.dmem_wdata = storeData(accSize, WriteDataM);
    assign bus.dmem_be    = laneMask(accSize) << lane;

    // Stalled, misaligned and timed-out cycles write a bubble so that each
    // instruction reaches writeback at most once.
    assign wBubble = FlushW || StallM || MisalignM || BusErrM;

    // ---- M -> W boundary ----
    always_ff @(posedge clk) begin
        if (rst || wBubble) begin
            RegWriteW    <= 1'b0;
            ResultSrcW   <= '0;
            ReadDataW    <= '0;
            ALUResultW   <= '0;
            PCPlus4W     <= '0;
            AuLu_ResultW <= '0;
            RdW          <= '0;
        end else begin
            RegWriteW    <= RegWriteM;
            ResultSrcW   <= ResultSrcM;
            ReadDataW    <= loadDone ? extractLoad(bus.dmem_rdata, lane, Funct3M) : '0;
            ALUResultW   <= ALUResultM;
            PCPlus4W     <= PCPlus4M;
            AuLu_ResultW <= AuLu_ResultM;
            RdW          <= RdM;
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Randomised bench for mem_stage_lsu (XLEN=32, RSP_TIMEOUT=4). Each
// instruction is described at transaction level (grant delay, response delay,
// flush) and the expected per-cycle bus/stall/flag behaviour and writeback
// are derived from the access rules with plain arithmetic.
module tb_mem_stage_lsu;
    localparam int XLEN  = 32;
    localparam int REG_W = 5;
    localparam int TMO   = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             ValidM, RegWriteM, MemWriteM, MemReadM, FlushW;
    logic [1:0]       ResultSrcM;
    logic [2:0]       Funct3M;
    logic [XLEN-1:0]  ALUResultM, WriteDataM, PCPlus4M, AuLu_ResultM;
    logic [REG_W-1:0] RdM;
    logic             StallM, MisalignM, BusErrM, RegWriteW;
    logic [1:0]       ResultSrcW;
    logic [XLEN-1:0]  ReadDataW, ALUResultW, PCPlus4W, AuLu_ResultW;
    logic [REG_W-1:0] RdW;

    int nChecks = 0;
    int nFails  = 0;

    always #5 clk = ~clk;

    mem_stage_lsu_if #(.XLEN(XLEN)) bus ();

    mem_stage_lsu #(.XLEN(XLEN), .REG_W(REG_W), .RSP_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .ValidM(ValidM), .RegWriteM(RegWriteM),
        .MemWriteM(MemWriteM), .MemReadM(MemReadM), .ResultSrcM(ResultSrcM),
        .Funct3M(Funct3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .PCPlus4M(PCPlus4M), .AuLu_ResultM(AuLu_ResultM), .RdM(RdM),
        .FlushW(FlushW), .bus(bus), .StallM(StallM), .MisalignM(MisalignM),
        .BusErrM(BusErrM), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
        .ReadDataW(ReadDataW), .ALUResultW(ALUResultW), .PCPlus4W(PCPlus4W),
        .AuLu_ResultW(AuLu_ResultW), .RdW(RdW)
    );

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Gather nB bytes starting at byte 'lane', then extend from the top byte.
    function automatic logic [31:0] refLoad(input logic [31:0] word, input int lane,
                                            input int nB, input bit uns);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < nB; i++) v = v | (32'(word[8*(lane+i) +: 8]) << (8*i));
        if (!uns && nB < 4 && v[8*nB-1]) v = v | (32'hFFFF_FFFF << (8*nB));
        return v;
    endfunction

    task automatic checkWAll0(input string tag);
        checkVal({tag, "_regw"}, RegWriteW, 0);
        checkVal({tag, "_rsrc"}, ResultSrcW, 0);
        checkVal({tag, "_rdata"}, ReadDataW, 0);
        checkVal({tag, "_alu"}, ALUResultW, 0);
        checkVal({tag, "_pc4"}, PCPlus4W, 0);
        checkVal({tag, "_aulu"}, AuLu_ResultW, 0);
        checkVal({tag, "_rd"}, RdW, 0);
    endtask

    // One instruction through M. Called just after a posedge; returns just
    // after the posedge that retires it.
    task automatic runOp(input bit vld, input bit ld, input bit st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                         input int gntDly, input int rspDly, input bit flush);
        int nB, lane, waitCyc, total;
        bit memOp, mis, legal, tout, last;
        logic [3:0]  expBe;
        logic [31:0] expWd, beMask, expRd;
        memOp = vld && (ld || st);
        nB    = 1 << f3[1:0];
        lane  = int'(addr[1:0]);
        mis   = memOp && (f3[1:0] == 2'b11 || (addr % nB) != 0);
        legal = memOp && !mis;
        tout  = 0;
        waitCyc = 0;
        if (legal && !st) begin
            tout    = rspDly > TMO;
            waitCyc = tout ? TMO : rspDly;
        end
        total = legal ? gntDly + 1 + waitCyc : 1;
        expBe = 4'((1 << nB) - 1) << lane;
        expWd = '0;
        beMask = '0;
        for (int i = 0; i < nB && lane + i < 4; i++) begin
            expWd[8*(lane+i) +: 8]  = wd[8*i +: 8];
            beMask[8*(lane+i) +: 8] = 8'hFF;
        end
        expRd = refLoad(rd, lane, nB, f3[2]);

        ValidM = vld; MemReadM = ld; MemWriteM = st; Funct3M = f3;
        ALUResultM = addr; WriteDataM = wd;
        RegWriteM = 1'($urandom); ResultSrcM = 2'($urandom); RdM = REG_W'($urandom);
        PCPlus4M = $urandom; AuLu_ResultM = $urandom;

        for (int c = 0; c < total; c++) begin
            last = (c == total - 1);
            if (legal) begin
                bus.dmem_gnt    = (c == gntDly);
                bus.dmem_rvalid = !st && !tout && (c == gntDly + rspDly);
                bus.dmem_rdata  = rd;
            end else begin
                // No access in flight: handshake inputs are noise to be ignored.
                bus.dmem_gnt    = 1'($urandom);
                bus.dmem_rvalid = 1'($urandom);
                bus.dmem_rdata  = $urandom;
            end
            FlushW = last ? flush : 1'($urandom);
            @(negedge clk);
            checkVal("stall", StallM, legal && !last);
            checkVal("misalign", MisalignM, mis);
            checkVal("buserr", BusErrM, tout && last);
            checkVal("req", bus.dmem_req, legal && c <= gntDly);
            if (legal && c <= gntDly) begin
                checkVal("addr", bus.dmem_addr, addr & 32'hFFFF_FFFC);
                checkVal("we", bus.dmem_we, st);
                checkVal("be", bus.dmem_be, expBe);
                if (st) checkVal("wdata", bus.dmem_wdata & beMask, expWd);
            end
            @(posedge clk);
            #1;
            if (last && !flush && !mis && !tout) begin
                checkVal("w_regw", RegWriteW, RegWriteM);
                checkVal("w_rsrc", ResultSrcW, ResultSrcM);
                checkVal("w_rdata", ReadDataW, (legal && ld && !st) ? expRd : 32'h0);
                checkVal("w_alu", ALUResultW, addr);
                checkVal("w_pc4", PCPlus4W, PCPlus4M);
                checkVal("w_aulu", AuLu_ResultW, AuLu_ResultM);
                checkVal("w_rd", RdW, RdM);
            end else begin
                checkVal("bubble_regw", RegWriteW, 0);
                checkVal("bubble_rd", RdW, 0);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; ValidM = 0; RegWriteM = 0; MemWriteM = 0; MemReadM = 0; FlushW = 0;
        ResultSrcM = 0; Funct3M = 0; ALUResultM = 0; WriteDataM = 0; PCPlus4M = 0;
        AuLu_ResultM = 0; RdM = 0;
        bus.dmem_gnt = 0; bus.dmem_rvalid = 0; bus.dmem_rdata = 0;
        repeat (2) @(posedge clk);
        #1;
        checkWAll0("rst");
        rst = 1'b0;
        @(negedge clk);
        checkVal("rst_req", bus.dmem_req, 0);
        checkVal("rst_stall", StallM, 0);
        checkVal("rst_mis", MisalignM, 0);
        checkVal("rst_berr", BusErrM, 0);
        @(posedge clk);
        #1;

        // Scenarios from the access rules
        runOp(1, 1, 0, 3'b010, 32'h104, 32'h0, 32'hDEAD_BEEF, 0, 3, 0);  // LW
        checkVal("lw_value", ReadDataW, 32'hDEAD_BEEF);
        runOp(1, 1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF_1234, 0, 2, 0);  // LB
        checkVal("lb_value", ReadDataW, 32'hFFFF_FF80);
        runOp(1, 1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF_1234, 1, 1, 0);  // LBU
        checkVal("lbu_value", ReadDataW, 32'h0000_0080);
        runOp(1, 1, 0, 3'b001, 32'h102, 32'h0, 32'h80FF_1234, 0, 4, 0);  // LH
        checkVal("lh_value", ReadDataW, 32'hFFFF_80FF);
        runOp(1, 0, 1, 3'b000, 32'h101, 32'hAB, 32'h0, 2, 1, 0);          // SB
        runOp(1, 1, 0, 3'b010, 32'h102, 32'h0, 32'h0, 0, 1, 0);           // misaligned LW
        runOp(1, 1, 0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 1, 0);           // LD on RV32
        runOp(1, 1, 0, 3'b010, 32'h200, 32'h0, 32'h1234_5678, 0, 9, 0);   // timeout
        runOp(1, 0, 0, 3'b000, 32'h55, 32'h0, 32'h0, 0, 1, 0);            // late rvalid noise
        runOp(1, 1, 0, 3'b010, 32'h204, 32'h0, 32'hCAFE_F00D, 1, 4, 0);   // rvalid on timeout cycle
        runOp(1, 0, 1, 3'b001, 32'h302, 32'h0000_BEEF, 32'h0, 0, 1, 1);   // flushed store

        // Reset while waiting for a response
        ValidM = 1; MemReadM = 1; MemWriteM = 0; Funct3M = 3'b010; ALUResultM = 32'h300;
        RegWriteM = 1; RdM = 5'd7; FlushW = 0;
        bus.dmem_gnt = 1; bus.dmem_rvalid = 0;
        @(posedge clk);
        #1;
        bus.dmem_gnt = 0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkWAll0("midrst");
        MemReadM = 0; RegWriteM = 1; RdM = 5'd9; FlushW = 1; bus.dmem_rvalid = 1;
        @(negedge clk);
        checkVal("midrst_req", bus.dmem_req, 0);
        checkVal("midrst_stall", StallM, 0);
        @(posedge clk);
        #1;
        checkVal("flush_regw", RegWriteW, 0);
        checkVal("flush_rd", RdW, 0);
        FlushW = 0; bus.dmem_rvalid = 0;
        runOp(1, 1, 0, 3'b010, 32'h400, 32'h0, 32'h0BAD_F00D, 1, 2, 0);

        // Random instruction mix
        repeat (300) begin
            int kind;
            bit ld, st, vld;
            logic [2:0]  f3;
            logic [31:0] addr;
            kind = $urandom_range(0, 9);
            ld   = (kind >= 3 && kind < 7);
            st   = (kind >= 7);
            vld  = ($urandom_range(0, 7) != 0);
            f3   = 3'($urandom);
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << f3[1:0]) - 32'd1);
            runOp(vld, ld, st, f3, addr, $urandom, $urandom,
                  $urandom_range(0, 3), $urandom_range(1, 6), $urandom_range(0, 5) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
